// File: rtl/lc3b_mem_responder.sv
// rtl/lc3b_mem_responder.sv - fixed-latency LC-3b memory responder with byte-enable word array
//
// Serves one read or write at a time. The request is latched when it is accepted in IDLE.
// A single-cycle mem_resp pulse completes the request LATENCY cycles after acceptance.
//
// Ports:
//   clk             - single clock; all state changes on its rising edge
//   rst             - synchronous active-high reset (array contents are kept)
//   mem_read        - read request, held by the initiator until mem_resp
//   mem_write       - write request, held by the initiator until mem_resp
//   mem_byte_enable - bit0 enables mem_wdata[7:0], bit1 enables mem_wdata[15:8]
//   mem_address     - byte address; the word index is mem_address[ADDR_BITS:1]
//   mem_wdata       - write data
//   mem_rdata       - registered read data, held until the next read completes
//   mem_resp        - registered one-cycle completion pulse
//   proto_err       - sticky protocol-violation flag, cleared only by rst

module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   op_idx;
  logic [15:0]            op_wdata;
  logic [1:0]             op_be;

  logic [15:0]            mem [0:(1<<ADDR_BITS)-1];

  logic                   req;
  logic                   accept;
  logic                   commit;
  logic                   c_write;
  logic [ADDR_BITS-1:0]   c_idx;
  logic [15:0]            c_wdata;
  logic [1:0]             c_be;
  logic [15:0]            c_old;
  logic [15:0]            c_merged;

  // Only the word-index bits of the byte address matter; the rest alias.
  logic                   unused_addr;
  assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  assign req    = mem_read | mem_write;
  assign accept = (state == S_IDLE) && req;

  // commit marks the edge that enters RESP. With LATENCY=1 that edge is the one
  // that accepts the request, so the operation comes straight from the inputs.
  // In every other case it comes from the latched copy.
  assign commit = (SINGLE && accept) || ((state == S_WAIT) && (cnt == 4'd1));

  always_comb begin
    c_write = op_write;
    c_idx   = op_idx;
    c_wdata = op_wdata;
    c_be    = op_be;
    if (state == S_IDLE) begin
      c_write = mem_write;
      c_idx   = mem_address[ADDR_BITS:1];
      c_wdata = mem_wdata;
      c_be    = mem_byte_enable;
    end
  end

  assign c_old    = mem[c_idx];
  assign c_merged = {c_be[1] ? c_wdata[15:8] : c_old[15:8],
                     c_be[0] ? c_wdata[7:0]  : c_old[7:0]};

  // The array is deliberately not reset. A reset edge suppresses the commit,
  // so a transaction that is abandoned in WAIT never writes.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_write) begin
      mem[c_idx] <= c_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      op_idx    <= '0;
      op_wdata  <= 16'h0000;
      op_be     <= 2'b00;
      mem_resp  <= 1'b0;
      mem_rdata <= 16'h0000;
      proto_err <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            // Read+write together is serviced as a write but is flagged.
            op_write <= mem_write;
            op_idx   <= mem_address[ADDR_BITS:1];
            op_wdata <= mem_wdata;
            op_be    <= mem_byte_enable;
            cnt      <= CNT_LOAD;
            if (mem_read && mem_write) begin
              proto_err <= 1'b1;
            end
            state <= SINGLE ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // The initiator must hold the request until mem_resp. Dropping it
          // early is flagged, but the transaction still completes.
          if (!req) begin
            proto_err <= 1'b1;
          end
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (commit) begin
        mem_resp <= 1'b1;
        if (!c_write) begin
          mem_rdata <= c_old;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb/tb_lc3b_mem_responder.sv - self-checking bench for lc3b_mem_responder

module tb_lc3b_mem_responder;

  localparam int AB  = 8;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_byte_enable = 2'b00;
  logic [15:0] mem_address = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a word array indexed by byte address modulo 2^(AB+1).
  logic [15:0] model_mem [0:(1<<AB)-1];
  logic [15:0] model_rd   = 16'h0000;
  logic        model_perr = 1'b0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        has_exp;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic int widx(input logic [15:0] addr);
    return (int'(addr) % (2 * (1 << AB))) / 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_apply(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wd, input logic [1:0] be);
    int i;
    i = widx(addr);
    if (rd && wr) model_perr = 1'b1;
    if (wr) begin
      if (be[0]) model_mem[i][7:0]  = wd[7:0];
      if (be[1]) model_mem[i][15:8] = wd[15:8];
    end else begin
      model_rd = model_mem[i];
    end
  endtask

  // Called at posedge+1 with the DUT idle. The request is held through RESP
  // and dropped just after the edge that ends RESP.
  task automatic do_req(input string nm, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be);
    int n;
    logic got;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      got = mem_resp;
    end
    chk({nm, " latency"}, 32'(n), 32'(LAT));
    model_apply(rd, wr, addr, wd, be);
    chk({nm, " rdata"}, 32'(mem_rdata), 32'(model_rd));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    chk({nm, " single resp"}, 32'(mem_resp), 32'd0);
    chk({nm, " proto_err"}, 32'(proto_err), 32'(model_perr));
  endtask

  initial begin
    int n;
    logic seen;
    logic [15:0] old;

    for (int i = 0; i < (1 << AB); i++) model_mem[i] = 16'h0000;

    vecs[0]  = '{"wr beef",    0, 1, 16'h0010, 16'hBEEF, 2'b11, 0, 16'h0000};
    vecs[1]  = '{"rd beef",    1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'hBEEF};
    vecs[2]  = '{"wr 1234",    0, 1, 16'h0020, 16'h1234, 2'b11, 0, 16'h0000};
    vecs[3]  = '{"wr hi ab",   0, 1, 16'h0020, 16'hAB00, 2'b10, 0, 16'h0000};
    vecs[4]  = '{"wr lo cd",   0, 1, 16'h0020, 16'h00CD, 2'b01, 0, 16'h0000};
    vecs[5]  = '{"rd abcd",    1, 0, 16'h0020, 16'h0000, 2'b11, 1, 16'hABCD};
    vecs[6]  = '{"wr be00",    0, 1, 16'h0020, 16'hFFFF, 2'b00, 0, 16'h0000};
    vecs[7]  = '{"rd abcd2",   1, 0, 16'h0020, 16'h0000, 2'b01, 1, 16'hABCD};
    vecs[8]  = '{"wr 5555",    0, 1, 16'h0001, 16'h5555, 2'b11, 0, 16'h0000};
    vecs[9]  = '{"rd alias0",  1, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h5555};
    vecs[10] = '{"rd alias200",1, 0, 16'h0200, 16'h0000, 2'b00, 1, 16'h5555};
    vecs[11] = '{"rd beef b2b",1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'hBEEF};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset mem_resp", 32'(mem_resp), 32'd0);
    chk("reset mem_rdata", 32'(mem_rdata), 32'h0);
    chk("reset proto_err", 32'(proto_err), 32'd0);

    // Directed vectors, issued back to back with no idle gap.
    foreach (vecs[k]) begin
      do_req(vecs[k].name, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wd, vecs[k].be);
      if (vecs[k].has_exp) chk({vecs[k].name, " expected"}, 32'(mem_rdata), 32'(vecs[k].exp));
    end

    // Reset one cycle after accepting a write abandons it.
    old = model_mem[widx(16'h0030)];
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h7777; mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    chk("rst in wait rdata", 32'(mem_rdata), 32'h0);
    chk("rst in wait perr", 32'(proto_err), 32'd0);
    rst = 1'b0;
    seen = mem_resp;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | mem_resp;
    end
    chk("rst in wait no resp", 32'(seen), 32'd0);
    model_rd = 16'h0000; model_perr = 1'b0;
    do_req("rd after abandon", 1, 0, 16'h0030, 16'h0000, 2'b11);
    chk("abandoned write kept old", 32'(mem_rdata), 32'(old));

    // Random traffic against the model.
    for (int k = 0; k < 150; k++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      do_req("rand", r, !r, 16'($urandom), 16'($urandom), 2'($urandom));
    end

    // Read and write asserted together is serviced as a write and is flagged.
    do_req("rw both", 1, 1, 16'h0040, 16'h0F0F, 2'b11);
    do_req("rd after both", 1, 0, 16'h0040, 16'h0000, 2'b00);
    chk("both value", 32'(mem_rdata), 32'h0F0F);
    chk("perr sticky", 32'(proto_err), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("perr cleared", 32'(proto_err), 32'd0);
    model_rd = 16'h0000; model_perr = 1'b0;

    // A read dropped in WAIT still completes on time and is flagged.
    mem_read = 1'b1; mem_address = 16'h0010;
    @(posedge clk); #1;
    mem_read = 1'b0;
    n = 1; seen = mem_resp;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = mem_resp;
    end
    chk("drop latency", 32'(n), 32'(LAT));
    chk("drop rdata", 32'(mem_rdata), 32'(model_mem[widx(16'h0010)]));
    chk("drop perr", 32'(proto_err), 32'd1);
    @(posedge clk); #1;
    chk("drop single resp", 32'(mem_resp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
